// File: rtl/wishbone_pkg.sv
// Shared types for the Wishbone pipelined-to-classic bridge.
package wishbone_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } bridge_state_t;

  typedef enum logic [1:0] {
    NONE,
    ACK,
    ERR,
    RTY
  } term_kind_t;

  // Resolve simultaneous target terminations: ERR > RTY > ACK.
  function automatic term_kind_t term_decode(logic ack, logic err, logic rty);
    if (err) begin
      return ERR;
    end else if (rty) begin
      return RTY;
    end else if (ack) begin
      return ACK;
    end
    return NONE;
  endfunction

endpackage

// File: rtl/wishbone_classic_bridge_if.sv
// Bundle of initiator-side (pipelined) and target-side (classic) Wishbone signals.
// slave: the bridge's view; master: the surrounding initiator/target environment.
interface wishbone_classic_bridge_if #(
  parameter int unsigned AddressWidth = 16,
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned Granularity  = 8
);
  localparam int unsigned SELWidth = DataWidth / Granularity;

  logic                    I_CYC_I;
  logic                    I_STB_I;
  logic                    I_WE_I;
  logic [AddressWidth-1:0] I_ADR_I;
  logic [SELWidth-1:0]     I_SEL_I;
  logic [DataWidth-1:0]    I_DAT_I;
  logic [DataWidth-1:0]    I_DAT_O;
  logic                    I_ACK_O;
  logic                    I_ERR_O;
  logic                    I_RTY_O;
  logic                    I_STALL_O;

  logic                    T_CYC_O;
  logic                    T_STB_O;
  logic                    T_WE_O;
  logic [AddressWidth-1:0] T_ADR_O;
  logic [SELWidth-1:0]     T_SEL_O;
  logic [DataWidth-1:0]    T_DAT_O;
  logic [DataWidth-1:0]    T_DAT_I;
  logic                    T_ACK_I;
  logic                    T_ERR_I;
  logic                    T_RTY_I;

  modport slave (
    input  I_CYC_I, I_STB_I, I_WE_I, I_ADR_I, I_SEL_I, I_DAT_I,
    output I_DAT_O, I_ACK_O, I_ERR_O, I_RTY_O, I_STALL_O,
    output T_CYC_O, T_STB_O, T_WE_O, T_ADR_O, T_SEL_O, T_DAT_O,
    input  T_DAT_I, T_ACK_I, T_ERR_I, T_RTY_I
  );

  modport master (
    output I_CYC_I, I_STB_I, I_WE_I, I_ADR_I, I_SEL_I, I_DAT_I,
    input  I_DAT_O, I_ACK_O, I_ERR_O, I_RTY_O, I_STALL_O,
    input  T_CYC_O, T_STB_O, T_WE_O, T_ADR_O, T_SEL_O, T_DAT_O,
    output T_DAT_I, T_ACK_I, T_ERR_I, T_RTY_I
  );

endinterface

// File: rtl/wishbone_timeout_counter.sv
// Watchdog for the bridge: counts consecutive BUSY cycles and flags expiry
// during the TimeoutCycles-th one.
module wishbone_timeout_counter #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic busy,
  output logic expired
);
  localparam logic [15:0] Limit = 16'(TimeoutCycles - 1);

  logic [15:0] count_q;

  // Count while busy; clear once the bridge leaves BUSY.
  always_ff @(posedge CLK_I) begin
    if (RST_I || !busy) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 16'd1;
    end
  end

  // Expiry is visible in the last allowed BUSY cycle so the bridge drops at that edge.
  always_comb begin
    expired = busy && (count_q == Limit);
  end

endmodule

// File: rtl/wishbone_classic_bridge.sv
// Converts one pipelined Wishbone request at a time into a classic single-beat cycle.
// Optional watchdog: define WISHBONE_BRIDGE_TIMEOUT_EN.
module wishbone_classic_bridge
  import wishbone_pkg::*;
#(
  parameter int unsigned AddressWidth  = 16,
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned Granularity   = 8,
  parameter int unsigned TimeoutCycles = 255
) (
  input logic                     CLK_I,
  input logic                     RST_I,
  wishbone_classic_bridge_if.slave bus
);
  localparam int unsigned SELWidth = DataWidth / Granularity;

  bridge_state_t           state_q, state_d;
  term_kind_t              resp_q, resp_d;
  term_kind_t              term;
  logic [AddressWidth-1:0] adr_q, adr_d;
  logic [SELWidth-1:0]     sel_q, sel_d;
  logic [DataWidth-1:0]    wdat_q, wdat_d;
  logic [DataWidth-1:0]    rdat_q, rdat_d;
  logic                    we_q, we_d;
  logic                    timeout;

`ifdef WISHBONE_BRIDGE_TIMEOUT_EN
  wishbone_timeout_counter #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .busy   (state_q == BUSY),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign term = term_decode(bus.T_ACK_I, bus.T_ERR_I, bus.T_RTY_I);

  // Next-state: accept in IDLE; in BUSY resolve abort > termination > watchdog.
  always_comb begin
    state_d = state_q;
    resp_d  = NONE;
    adr_d   = adr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (bus.I_CYC_I && bus.I_STB_I) begin
          adr_d   = bus.I_ADR_I;
          sel_d   = bus.I_SEL_I;
          wdat_d  = bus.I_DAT_I;
          we_d    = bus.I_WE_I;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!bus.I_CYC_I) begin
          state_d = IDLE;
        end else if (term != NONE) begin
          state_d = IDLE;
          resp_d  = term;
          if (term == ACK && !we_q) begin
            rdat_d = bus.T_DAT_I;
          end
        end else if (timeout) begin
          state_d = IDLE;
          resp_d  = ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured request, read data and one-cycle response register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      resp_q  <= NONE;
      adr_q   <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      we_q    <= we_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.T_CYC_O   = (state_q == BUSY);
    bus.T_STB_O   = (state_q == BUSY);
    bus.I_STALL_O = (state_q == BUSY);
    bus.T_WE_O    = we_q;
    bus.T_ADR_O   = adr_q;
    bus.T_SEL_O   = sel_q;
    bus.T_DAT_O   = wdat_q;
    bus.I_DAT_O   = rdat_q;
    bus.I_ACK_O   = (resp_q == ACK);
    bus.I_ERR_O   = (resp_q == ERR);
    bus.I_RTY_O   = (resp_q == RTY);
  end

endmodule

// File: tb/tb_wishbone_classic_bridge.sv
// Directed bench for wishbone_classic_bridge; timeout path follows WISHBONE_BRIDGE_TIMEOUT_EN.
module tb_wishbone_classic_bridge;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK_I = ~CLK_I;

  wishbone_classic_bridge_if #(
    .AddressWidth(16),
    .DataWidth   (8),
    .Granularity (8)
  ) bus ();

  wishbone_classic_bridge #(
    .AddressWidth (16),
    .DataWidth    (8),
    .Granularity  (8),
    .TimeoutCycles(4)
  ) dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .bus  (bus)
  );

  // Inputs change 1 time unit after the edge; outputs are read at the same point.
  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic quiet();
    bus.I_CYC_I = 0; bus.I_STB_I = 0; bus.I_WE_I = 0;
    bus.I_ADR_I = '0; bus.I_SEL_I = '0; bus.I_DAT_I = '0;
    bus.T_DAT_I = '0; bus.T_ACK_I = 0; bus.T_ERR_I = 0; bus.T_RTY_I = 0;
  endtask

  task automatic request(input logic we, input logic [15:0] adr, input logic [7:0] dat);
    bus.I_CYC_I = 1; bus.I_STB_I = 1; bus.I_WE_I = we;
    bus.I_ADR_I = adr; bus.I_SEL_I = 1'b1; bus.I_DAT_I = dat;
  endtask

  task automatic test_reset();
    quiet();
    RST_I = 1;
    tick(); tick();
    n_checks++; if (bus.T_CYC_O !== 1'b0) begin n_fail++; $display("FAIL reset_tcyc got=%b exp=0", bus.T_CYC_O); end
    n_checks++; if (bus.I_STALL_O !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", bus.I_STALL_O); end
    n_checks++; if (bus.I_DAT_O !== 8'h00) begin n_fail++; $display("FAIL reset_idat got=%h exp=00", bus.I_DAT_O); end
    n_checks++; if (bus.T_ADR_O !== 16'h0000) begin n_fail++; $display("FAIL reset_tadr got=%h exp=0000", bus.T_ADR_O); end
    n_checks++; if ({bus.I_ACK_O, bus.I_ERR_O, bus.I_RTY_O} !== 3'b000) begin n_fail++; $display("FAIL reset_term got=%b exp=000", {bus.I_ACK_O, bus.I_ERR_O, bus.I_RTY_O}); end
    RST_I = 0;
    tick();
  endtask

  task automatic test_ignored_inputs();
    // STB without CYC and a termination in IDLE must both be ignored.
    bus.I_STB_I = 1; bus.T_ACK_I = 1;
    tick();
    n_checks++; if (bus.T_CYC_O !== 1'b0) begin n_fail++; $display("FAIL stb_no_cyc got=%b exp=0", bus.T_CYC_O); end
    tick();
    n_checks++; if (bus.I_ACK_O !== 1'b0) begin n_fail++; $display("FAIL idle_ack got=%b exp=0", bus.I_ACK_O); end
    quiet();
    tick();
  endtask

  task automatic test_read();
    int stall_cycles = 0;
    request(1'b0, 16'h1234, 8'h00);
    tick();
    bus.I_STB_I = 0;
    n_checks++; if ({bus.T_CYC_O, bus.T_STB_O, bus.T_WE_O} !== 3'b110) begin n_fail++; $display("FAIL read_treq got=%b exp=110", {bus.T_CYC_O, bus.T_STB_O, bus.T_WE_O}); end
    n_checks++; if (bus.T_ADR_O !== 16'h1234) begin n_fail++; $display("FAIL read_tadr got=%h exp=1234", bus.T_ADR_O); end
    if (bus.I_STALL_O) stall_cycles++;
    tick();
    n_checks++; if (bus.T_STB_O !== 1'b1) begin n_fail++; $display("FAIL read_hold got=%b exp=1", bus.T_STB_O); end
    if (bus.I_STALL_O) stall_cycles++;
    bus.T_ACK_I = 1; bus.T_DAT_I = 8'hA5;
    tick();
    if (bus.I_STALL_O) stall_cycles++;
    bus.T_ACK_I = 0; bus.T_DAT_I = 8'h00;
    n_checks++; if (bus.I_ACK_O !== 1'b1) begin n_fail++; $display("FAIL read_ack got=%b exp=1", bus.I_ACK_O); end
    n_checks++; if (bus.I_DAT_O !== 8'hA5) begin n_fail++; $display("FAIL read_data got=%h exp=a5", bus.I_DAT_O); end
    n_checks++; if (bus.T_CYC_O !== 1'b0) begin n_fail++; $display("FAIL read_tcyc_drop got=%b exp=0", bus.T_CYC_O); end
    tick();
    n_checks++; if (bus.I_ACK_O !== 1'b0) begin n_fail++; $display("FAIL read_ack_pulse got=%b exp=0", bus.I_ACK_O); end
    n_checks++; if (stall_cycles !== 2) begin n_fail++; $display("FAIL read_stall_len got=%0d exp=2", stall_cycles); end
    quiet();
    tick();
  endtask

  task automatic test_write_err();
    request(1'b1, 16'h00F0, 8'h3C);
    tick();
    bus.I_STB_I = 0;
    n_checks++; if ({bus.T_WE_O, bus.T_DAT_O} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL write_treq got=%b/%h exp=1/3c", bus.T_WE_O, bus.T_DAT_O); end
    bus.T_ACK_I = 1; bus.T_ERR_I = 1;
    tick();
    bus.T_ACK_I = 0; bus.T_ERR_I = 0;
    n_checks++; if ({bus.I_ACK_O, bus.I_ERR_O, bus.I_RTY_O} !== 3'b010) begin n_fail++; $display("FAIL write_err got=%b exp=010", {bus.I_ACK_O, bus.I_ERR_O, bus.I_RTY_O}); end
    n_checks++; if (bus.I_DAT_O !== 8'hA5) begin n_fail++; $display("FAIL write_idat got=%h exp=a5", bus.I_DAT_O); end
    tick();
    n_checks++; if (bus.I_ERR_O !== 1'b0) begin n_fail++; $display("FAIL write_err_pulse got=%b exp=0", bus.I_ERR_O); end
    quiet();
    tick();
  endtask

  task automatic test_retry();
    // RTY outranks ACK, and a retried read must not load data.
    request(1'b0, 16'h0042, 8'h00);
    tick();
    bus.I_STB_I = 0;
    bus.T_ACK_I = 1; bus.T_RTY_I = 1; bus.T_DAT_I = 8'h77;
    tick();
    bus.T_ACK_I = 0; bus.T_RTY_I = 0;
    n_checks++; if ({bus.I_ACK_O, bus.I_ERR_O, bus.I_RTY_O} !== 3'b001) begin n_fail++; $display("FAIL retry_term got=%b exp=001", {bus.I_ACK_O, bus.I_ERR_O, bus.I_RTY_O}); end
    n_checks++; if (bus.I_DAT_O !== 8'hA5) begin n_fail++; $display("FAIL retry_idat got=%h exp=a5", bus.I_DAT_O); end
    quiet();
    tick();
  endtask

  task automatic test_back_to_back();
    request(1'b0, 16'h0010, 8'h00);
    tick();
    // Next request presented while stalled; zero-wait target acks the first.
    request(1'b0, 16'h0020, 8'h00);
    bus.T_ACK_I = 1; bus.T_DAT_I = 8'h11;
    tick();
    bus.T_ACK_I = 0;
    n_checks++; if ({bus.I_ACK_O, bus.I_STALL_O} !== 2'b10) begin n_fail++; $display("FAIL b2b_first got=%b exp=10", {bus.I_ACK_O, bus.I_STALL_O}); end
    n_checks++; if (bus.I_DAT_O !== 8'h11) begin n_fail++; $display("FAIL b2b_data1 got=%h exp=11", bus.I_DAT_O); end
    tick();
    bus.I_STB_I = 0;
    n_checks++; if ({bus.T_STB_O, bus.T_ADR_O} !== {1'b1, 16'h0020}) begin n_fail++; $display("FAIL b2b_accept got=%b/%h exp=1/0020", bus.T_STB_O, bus.T_ADR_O); end
    n_checks++; if (bus.I_ACK_O !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got=%b exp=0", bus.I_ACK_O); end
    bus.T_ACK_I = 1; bus.T_DAT_I = 8'h22;
    tick();
    bus.T_ACK_I = 0;
    n_checks++; if (bus.I_ACK_O !== 1'b1) begin n_fail++; $display("FAIL b2b_second got=%b exp=1", bus.I_ACK_O); end
    n_checks++; if (bus.I_DAT_O !== 8'h22) begin n_fail++; $display("FAIL b2b_data2 got=%h exp=22", bus.I_DAT_O); end
    quiet();
    tick();
  endtask

  task automatic test_abort();
    request(1'b0, 16'h0033, 8'h00);
    tick();
    bus.I_CYC_I = 0; bus.I_STB_I = 0;
    bus.T_ACK_I = 1; bus.T_DAT_I = 8'h99;
    tick();
    bus.T_ACK_I = 0;
    n_checks++; if (bus.T_CYC_O !== 1'b0) begin n_fail++; $display("FAIL abort_tcyc got=%b exp=0", bus.T_CYC_O); end
    n_checks++; if ({bus.I_ACK_O, bus.I_ERR_O, bus.I_RTY_O} !== 3'b000) begin n_fail++; $display("FAIL abort_term got=%b exp=000", {bus.I_ACK_O, bus.I_ERR_O, bus.I_RTY_O}); end
    n_checks++; if (bus.I_DAT_O !== 8'h22) begin n_fail++; $display("FAIL abort_idat got=%h exp=22", bus.I_DAT_O); end
    tick();
    n_checks++; if ({bus.I_ACK_O, bus.I_ERR_O, bus.I_RTY_O} !== 3'b000) begin n_fail++; $display("FAIL abort_late got=%b exp=000", {bus.I_ACK_O, bus.I_ERR_O, bus.I_RTY_O}); end
    quiet();
    tick();
  endtask

  task automatic test_reset_mid_busy();
    request(1'b1, 16'h0055, 8'h5A);
    tick();
    bus.I_STB_I = 0;
    RST_I = 1; bus.T_ACK_I = 1;
    tick();
    RST_I = 0; bus.T_ACK_I = 0;
    n_checks++; if ({bus.T_CYC_O, bus.I_ACK_O} !== 2'b00) begin n_fail++; $display("FAIL rst_busy got=%b exp=00", {bus.T_CYC_O, bus.I_ACK_O}); end
    n_checks++; if ({bus.T_ADR_O, bus.T_DAT_O, bus.I_DAT_O} !== 32'h0) begin n_fail++; $display("FAIL rst_busy_regs got=%h exp=0", {bus.T_ADR_O, bus.T_DAT_O, bus.I_DAT_O}); end
    tick();
    n_checks++; if (bus.I_ACK_O !== 1'b0) begin n_fail++; $display("FAIL rst_busy_late got=%b exp=0", bus.I_ACK_O); end
    quiet();
    tick();
  endtask

  task automatic test_timeout();
    int stb_cycles = 0;
    int err_seen = 0;
    request(1'b0, 16'h0077, 8'h00);
    tick();
    bus.I_STB_I = 0;
`ifdef WISHBONE_BRIDGE_TIMEOUT_EN
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (bus.T_STB_O && !bus.I_ERR_O) stb_cycles++;
    end
    n_checks++; if (stb_cycles !== 3) begin n_fail++; $display("FAIL to_wait got=%0d exp=3", stb_cycles); end
    tick();
    n_checks++; if ({bus.I_ERR_O, bus.T_CYC_O} !== 2'b10) begin n_fail++; $display("FAIL to_err got=%b exp=10", {bus.I_ERR_O, bus.T_CYC_O}); end
    tick();
    n_checks++; if (bus.I_ERR_O !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse got=%b exp=0", bus.I_ERR_O); end
`else
    for (int i = 0; i < 100; i++) begin
      if (bus.T_STB_O) stb_cycles++;
      if (bus.I_ERR_O) err_seen++;
      tick();
    end
    n_checks++; if (stb_cycles !== 100) begin n_fail++; $display("FAIL no_to_stb got=%0d exp=100", stb_cycles); end
    n_checks++; if (err_seen !== 0) begin n_fail++; $display("FAIL no_to_err got=%0d exp=0", err_seen); end
`endif
    quiet();
    tick();
    n_checks++; if (bus.T_CYC_O !== 1'b0) begin n_fail++; $display("FAIL to_idle got=%b exp=0", bus.T_CYC_O); end
  endtask

  initial begin
    test_reset();
    test_ignored_inputs();
    test_read();
    test_write_err();
    test_retry();
    test_back_to_back();
    test_abort();
    test_reset_mid_busy();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/wishbone_classic_bridge.md
WISHBONE_CLASSIC_BRIDGE -- requirements
Module: wishbone_classic_bridge

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named CLK_I and RST_I.
REQ-002 Parameter AddressWidth, default 16: address width in bits.
REQ-003 Parameter DataWidth, default 8: data width in bits (8/16/32/64).
REQ-004 Parameter Granularity, default 8: byte-select granularity; SELWidth = DataWidth/Granularity.
REQ-005 Parameter TimeoutCycles, default 255: watchdog limit, range 1..65535.
REQ-006 CLK_I  in  1  system clock.
REQ-007 RST_I  in  1  synchronous active-high reset.
REQ-008 I_CYC_I, I_STB_I, I_WE_I  in  1 each  pipelined-initiator cycle, strobe and write-enable.
REQ-009 I_ADR_I  in  AddressWidth  initiator address.
REQ-010 I_SEL_I  in  SELWidth  initiator byte selects.
REQ-011 I_DAT_I  in  DataWidth  initiator write data.
REQ-012 I_DAT_O  out  DataWidth  read data returned to the initiator.
REQ-013 I_ACK_O, I_ERR_O, I_RTY_O  out  1 each  initiator terminations.
REQ-014 I_STALL_O  out  1  pipelined stall.
REQ-015 T_CYC_O, T_STB_O, T_WE_O  out  1 each  classic-target cycle, strobe and write-enable.
REQ-016 T_ADR_O / T_SEL_O / T_DAT_O  out  AddressWidth / SELWidth / DataWidth  registered target request.
REQ-017 T_DAT_I  in  DataWidth  target read data.
REQ-018 T_ACK_I, T_ERR_I, T_RTY_I  in  1 each  classic-target terminations.

Function
REQ-019 The bridge SHALL be the downstream consumer of the pipelined skid buffer, converting one pipelined request at a time into a classic single-beat cycle; states are IDLE and BUSY.
REQ-020 IDLE: I_STALL_O=0 and T_CYC_O=T_STB_O=0; a request is accepted when I_CYC_I & I_STB_I; STB without CYC is ignored.
REQ-021 On acceptance, T_ADR_O/T_SEL_O/T_WE_O/T_DAT_O SHALL be captured and the state SHALL enter BUSY, with T_CYC_O=T_STB_O=1 from the next cycle (1-cycle request latency).
REQ-022 BUSY: I_STALL_O=1, and all T_* request outputs SHALL be held stable until termination.
REQ-023 Termination is any of T_ACK_I/T_ERR_I/T_RTY_I sampled high in BUSY; priority is ERR > RTY > ACK.
REQ-024 At the termination edge, T_CYC_O/T_STB_O SHALL deassert and the state SHALL return to IDLE.
REQ-025 In the following cycle, exactly one of I_ACK_O/I_ERR_O/I_RTY_O SHALL pulse high for one cycle.
REQ-026 On a termination by T_ACK_I with T_WE_O=0, I_DAT_O SHALL load T_DAT_I; otherwise I_DAT_O holds its previous value.
REQ-027 A new request SHALL be acceptable in the same cycle the response pulses (stall is low then), sustaining one transaction per 2 cycles with a zero-wait target.
REQ-028 I_CYC_I low while BUSY SHALL abort: T_CYC_O/T_STB_O drop at the next edge, no initiator termination is issued, and the state returns to IDLE; abort wins over a simultaneous termination.
REQ-029 Terminations arriving in IDLE SHALL be ignored.

Reset
REQ-030 When RST_I is sampled high, state=IDLE; T_CYC_O, T_STB_O, T_WE_O, I_ACK_O, I_ERR_O, I_RTY_O = 0; I_DAT_O, T_ADR_O, T_SEL_O, T_DAT_O = 0; watchdog count = 0.
REQ-031 Reset mid-BUSY SHALL drop T_CYC_O at that edge and emit no initiator termination.

Configuration
REQ-032 With WISHBONE_BRIDGE_TIMEOUT_EN defined, a counter SHALL count BUSY cycles; when TimeoutCycles cycles elapse without termination, the bridge SHALL drop T_CYC_O, return to IDLE and pulse I_ERR_O once.
REQ-033 Without WISHBONE_BRIDGE_TIMEOUT_EN, no counter SHALL exist and BUSY SHALL wait indefinitely.

Structure
REQ-034 Package wishbone_pkg SHALL hold bridge_state_t (IDLE, BUSY) and the termination-kind enum (NONE, ACK, ERR, RTY).
REQ-035 The watchdog SHALL be sub-module wishbone_timeout_counter, instantiated only under WISHBONE_BRIDGE_TIMEOUT_EN.

Verification
REQ-036 Read at 0x1234, target ACK one cycle after STB with T_DAT_I=0xA5 -> I_ACK_O one pulse, I_DAT_O=0xA5, I_STALL_O high exactly 2 cycles.
REQ-037 Write 0x3C, target asserts ACK and ERR together -> single I_ERR_O pulse, no I_ACK_O, I_DAT_O unchanged.
REQ-038 Back-to-back pipelined reads with a zero-wait target -> second request accepted in the response cycle, 2-cycle spacing.
REQ-039 I_CYC_I dropped in BUSY concurrent with T_ACK_I -> T_CYC_O low next edge, no initiator termination.
REQ-040 Timeout enabled, TimeoutCycles=4, silent target -> I_ERR_O pulse 4 cycles after STB; disabled -> T_STB_O stays high for 100 cycles.
